// File: rtl/tx_ffe_driver.sv
// Transmit driver with an N-tap feed-forward equaliser over +/-1 symbols,
// a saturating fixed-point output stage and a built-in PRBS7 source.
module tx_ffe_driver #(
  parameter int N_TAPS    = 3,
  parameter int TAP_WIDTH = 8,
  parameter int TAP_POINT = 6,
  parameter int OUT_WIDTH = 18,
  parameter int OUT_POINT = 14
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in,
  input  logic                                            en,
  input  logic                                            src_sel,
  input  logic                                            tap_wr,
  input  logic [((N_TAPS > 1) ? $clog2(N_TAPS) : 1)-1:0]  tap_addr,
  input  logic signed [TAP_WIDTH-1:0]                     tap_data,
  output logic signed [OUT_WIDTH-1:0]                     out,
  output logic                                            out_valid,
  output logic                                            prbs_bit
);

  localparam int AW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int FW    = $clog2(N_TAPS + 1);
  localparam int ACC_W = TAP_WIDTH + $clog2(N_TAPS) + 1;
  localparam int SHIFT = OUT_POINT - TAP_POINT;
  localparam int SUM_W = ((ACC_W + SHIFT > OUT_WIDTH) ? (ACC_W + SHIFT) : OUT_WIDTH) + 1;

  localparam logic [FW-1:0]               FILL_FULL = FW'(N_TAPS);
  localparam logic signed [TAP_WIDTH-1:0] TAP_ONE   = TAP_WIDTH'(32'sd1 <<< TAP_POINT);
  localparam logic [6:0]                  LFSR_SEED = 7'h7F;
  localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [N_TAPS-1:0]           hist_q, hist_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic [6:0]                  lfsr_q, lfsr_d;
  logic                        accepted_q, accepted_d;
  logic signed [TAP_WIDTH-1:0] taps_q [N_TAPS];
  logic signed [TAP_WIDTH-1:0] taps_d [N_TAPS];
  logic signed [OUT_WIDTH-1:0] out_q, out_d;
  logic                        out_valid_q, out_valid_d;

  logic                        bit_s;
  logic signed [ACC_W-1:0]     tap_ext_s;
  logic signed [ACC_W-1:0]     acc_s;
  logic signed [SUM_W-1:0]     acc_ext_s;
  logic signed [SUM_W-1:0]     shifted_s;
  logic signed [OUT_WIDTH-1:0] sat_s;

  assign bit_s = src_sel ? lfsr_q[6] : in;

  // hist bit 1 adds the tap weight, bit 0 subtracts it
  always_comb begin
    acc_s     = '0;
    tap_ext_s = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      tap_ext_s = {{(ACC_W-TAP_WIDTH){taps_q[k][TAP_WIDTH-1]}}, taps_q[k]};
      if (hist_q[k]) begin
        acc_s = acc_s + tap_ext_s;
      end else begin
        acc_s = acc_s - tap_ext_s;
      end
    end
  end

  always_comb begin
    acc_ext_s = {{(SUM_W-ACC_W){acc_s[ACC_W-1]}}, acc_s};
    shifted_s = acc_ext_s <<< SHIFT;
    if (shifted_s > OUT_MAX) begin
      sat_s = OUT_MAX[OUT_WIDTH-1:0];
    end else if (shifted_s < OUT_MIN) begin
      sat_s = OUT_MIN[OUT_WIDTH-1:0];
    end else begin
      sat_s = shifted_s[OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    hist_d      = hist_q;
    fill_d      = fill_q;
    lfsr_d      = lfsr_q;
    accepted_d  = en;
    taps_d      = taps_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (en) begin
      hist_d = N_TAPS'({hist_q, bit_s});
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FW'(1);
      end else begin
        fill_d = fill_q;
      end
      if (src_sel) begin
        lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
      end else begin
        lfsr_d = lfsr_q;
      end
    end else begin
      hist_d = hist_q;
    end

    // addresses at or beyond N_TAPS never match a tap, so they are dropped
    for (int k = 0; k < N_TAPS; k++) begin
      if (tap_wr && (tap_addr == AW'(k))) begin
        taps_d[k] = tap_data;
      end else begin
        taps_d[k] = taps_q[k];
      end
    end

    // the sum uses pre-edge history and taps, giving two-cycle latency
    if (accepted_q) begin
      if (fill_q == FILL_FULL) begin
        out_d       = sat_s;
        out_valid_d = 1'b1;
      end else begin
        out_d       = '0;
        out_valid_d = 1'b0;
      end
    end else begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q      <= '0;
      fill_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      accepted_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        if (k == 0) begin
          taps_q[k] <= TAP_ONE;
        end else begin
          taps_q[k] <= '0;
        end
      end
    end else begin
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      lfsr_q      <= lfsr_d;
      accepted_q  <= accepted_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      taps_q      <= taps_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign prbs_bit  = lfsr_q[6];

endmodule

// File: tb/tb_tx_ffe_driver.sv
// Bench for tx_ffe_driver: a default instance and an OUT_POINT=16 instance share
// stimulus; an integer-arithmetic model is checked every cycle, plus literal values.
module tb_tx_ffe_driver;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, din = 1'b0, en = 1'b0, src_sel = 1'b0, tap_wr = 1'b0;
  logic [1:0]        tap_addr = 2'd0;
  logic signed [7:0] tap_data = 8'sd0;
  logic signed [17:0] out_a, out_b;
  logic              val_a, val_b, prbs_a, prbs_b;

  tx_ffe_driver u_dut_a (
    .clk(clk), .rst(rst), .in(din), .en(en), .src_sel(src_sel), .tap_wr(tap_wr),
    .tap_addr(tap_addr), .tap_data(tap_data), .out(out_a), .out_valid(val_a), .prbs_bit(prbs_a)
  );

  tx_ffe_driver #(.OUT_POINT(16)) u_dut_b (
    .clk(clk), .rst(rst), .in(din), .en(en), .src_sel(src_sel), .tap_wr(tap_wr),
    .tap_addr(tap_addr), .tap_data(tap_data), .out(out_b), .out_valid(val_b), .prbs_bit(prbs_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int      prbs_seq [127];
  int      hist_m [$];          // newest symbol bit at index 0
  int      taps_m [N];
  int      idx_m   = 0;
  bit      pend_m  = 1'b0;
  longint  exp_a   = 0;
  longint  exp_b   = 0;
  bit      exp_val = 1'b0;

  function automatic longint model_out(int op);
    longint acc = 0;
    longint lim = longint'(1) << 17;
    for (int k = 0; k < N; k++) acc += (hist_m[k] != 0) ? taps_m[k] : -taps_m[k];
    acc = acc * (longint'(1) << (op - 6));
    if (acc > lim - 1) acc = lim - 1;
    if (acc < -lim) acc = -lim;
    return acc;
  endfunction

  initial begin
    for (int i = 0; i < 7; i++) prbs_seq[i] = 1;
    for (int i = 0; i < 120; i++) prbs_seq[i+7] = prbs_seq[i] ^ prbs_seq[i+1];
    for (int k = 0; k < N; k++) taps_m[k] = (k == 0) ? 64 : 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        hist_m.delete();
        pend_m = 1'b0; idx_m = 0; exp_a = 0; exp_b = 0; exp_val = 1'b0;
        for (int k = 0; k < N; k++) taps_m[k] = (k == 0) ? 64 : 0;
      end else begin
        if (pend_m) begin
          if (hist_m.size() == N) begin
            exp_a = model_out(14); exp_b = model_out(16); exp_val = 1'b1;
          end else begin
            exp_a = 0; exp_b = 0; exp_val = 1'b0;
          end
        end
        if (tap_wr && tap_addr < N) taps_m[tap_addr] = int'(tap_data);
        if (en) begin
          int b;
          b = src_sel ? prbs_seq[idx_m % 127] : int'(din);
          if (src_sel) idx_m++;
          hist_m.push_front(b);
          if (hist_m.size() > N) void'(hist_m.pop_back());
        end
        pend_m = en;
      end
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("model out_a", out_a, exp_a);
        chk("model out_b", out_b, exp_b);
        chk("model valid_a", val_a, exp_val);
        chk("model valid_b", val_b, exp_val);
        chk("model prbs_a", prbs_a, prbs_seq[idx_m % 127]);
        chk("model prbs_b", prbs_b, prbs_seq[idx_m % 127]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic d, input logic e, input logic s,
                     input logic w, input logic [1:0] a, input logic signed [7:0] t);
    rst = r; din = d; en = e; src_sel = s; tap_wr = w; tap_addr = a; tap_data = t;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic d);
    cyc(1'b0, d, 1'b1, 1'b0, 1'b0, 2'd0, 8'sd0);
  endtask

  task automatic wr_tap(input logic [1:0] a, input logic signed [7:0] t);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, t);
  endtask

  int         rec [127];
  logic [7:0] first8;
  int         ones;
  int         mism;

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'sd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'sd0);
    chk_on = 1'b1;
    chk("reset out", out_a, 0);
    chk("reset valid", val_a, 0);
    chk("reset prbs", prbs_a, 1);

    // default NRZ
    send(1'b1); send(1'b0); send(1'b1);
    chk("nrz fill valid", val_a, 0);
    chk("nrz fill out", out_a, 0);
    send(1'b1);
    chk("nrz first out", out_a, 16384);
    chk("nrz first valid", val_a, 1);
    send(1'b1); send(1'b0); send(1'b1);
    chk("nrz minus", out_a, -16384);

    // de-emphasis taps, written while stalled
    wr_tap(2'd0, 8'sd48);
    chk("old tap used", out_a, 16384);
    wr_tap(2'd1, -8'sd16);
    chk("stall hold out", out_a, 16384);
    chk("stall hold valid", val_a, 1);
    wr_tap(2'd2, 8'sd0);
    send(1'b0); send(1'b0); send(1'b1); send(1'b1);
    chk("deemph rise", out_a, 16384);
    send(1'b1);
    chk("deemph run", out_a, 8192);
    send(1'b0); send(1'b0);
    chk("deemph fall", out_a, -16384);
    send(1'b0);

    // out-of-range tap address is ignored
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'sd100);
    send(1'b0);
    chk("illegal addr", out_a, -8192);

    // saturation
    wr_tap(2'd0, 8'sd127); wr_tap(2'd1, 8'sd127); wr_tap(2'd2, 8'sd127);
    send(1'b1); send(1'b1); send(1'b1); send(1'b1);
    chk("sat pos a", out_a, 97536);
    chk("sat pos b", out_b, 131071);
    send(1'b0); send(1'b0); send(1'b0); send(1'b0);
    chk("sat neg a", out_a, -97536);
    chk("sat neg b", out_b, -131072);

    // mid-stream reset
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'sd0);
    chk("midrst out", out_a, 0);
    chk("midrst valid", val_a, 0);
    chk("midrst prbs", prbs_a, 1);
    send(1'b1); send(1'b0); send(1'b1);
    chk("refill valid low", val_a, 0);
    send(1'b1);
    chk("refill valid", val_a, 1);
    chk("refill default tap a", out_a, 16384);
    chk("refill default tap b", out_b, 65536);

    // PRBS7 with a 5-cycle stall inside the first period
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'sd0);
    ones = 0;
    for (int i = 0; i < 127; i++) begin
      if (i == 60) for (int j = 0; j < 5; j++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'sd0);
      rec[i] = int'(prbs_a);
      ones += rec[i];
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'sd0);
    end
    first8 = 8'h00;
    for (int i = 0; i < 8; i++) first8 = {first8[6:0], rec[i][0]};
    chk("prbs first8", first8, 8'hFE);
    chk("prbs ones per period", ones, 64);

    // second period, with a detour through the external source
    mism = 0;
    for (int i = 0; i < 127; i++) begin
      if (i == 30) for (int j = 0; j < 3; j++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'sd0);
      if (int'(prbs_a) != rec[i]) mism++;
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'sd0);
    end
    chk("prbs period 127", mism, 0);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'sd0);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
